// File: rtl/neuron_pkg.sv
// neuron_pkg: frame FSM states, saturation limits and flat-bus lane helper shared by neuron_layer_mac.
// The ARGMAX state exists only when NEURON_ARGMAX_EN is defined.
package neuron_pkg;
   typedef enum logic [2:0] {
      S_IDLE,
      S_ACCUM,
      S_DRAIN,
`ifdef NEURON_ARGMAX_EN
      S_ARGMAX,
`endif
      S_DONE
   } state_t;
   function automatic longint sat_max(input int w);
      return (longint'(1) <<< (w - 1)) - 1;
   endfunction
   function automatic longint sat_min(input int w);
      return -(longint'(1) <<< (w - 1));
   endfunction
   function automatic int lane_lsb(input int k, input int w);
      return k * w;
   endfunction
endpackage

// File: rtl/neuron_mac_lane.sv
// neuron_mac_lane: one fixed-point MAC lane with registered product, shift/saturate and saturating accumulator.
module neuron_mac_lane
   import neuron_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int FRAC_W = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_load,
   input  logic                     i_acc,
   input  logic                     i_add,
   input  logic signed [DATA_W-1:0] i_bias,
   input  logic signed [DATA_W-1:0] i_value,
   input  logic signed [DATA_W-1:0] i_weight,
   output logic signed [DATA_W-1:0] o_sum
);
   localparam logic signed [2*DATA_W-1:0] P_MAX = (2*DATA_W)'(sat_max(DATA_W));
   localparam logic signed [2*DATA_W-1:0] P_MIN = (2*DATA_W)'(sat_min(DATA_W));
   localparam logic signed [DATA_W:0]     S_MAX = (DATA_W+1)'(sat_max(DATA_W));
   localparam logic signed [DATA_W:0]     S_MIN = (DATA_W+1)'(sat_min(DATA_W));
   logic signed [2*DATA_W-1:0] r_prod, w_sh;
   logic signed [DATA_W-1:0]   w_term, w_sat, r_sum;
   logic signed [DATA_W:0]     w_add;
   assign w_sh   = r_prod >>> FRAC_W;
   assign w_term = w_sh > P_MAX ? P_MAX[DATA_W-1:0] : w_sh < P_MIN ? P_MIN[DATA_W-1:0] : w_sh[DATA_W-1:0];
   // one guard bit so the clamp sees the true sum instead of a wrapped one
   assign w_add  = {r_sum[DATA_W-1], r_sum} + {w_term[DATA_W-1], w_term};
   assign w_sat  = w_add > S_MAX ? S_MAX[DATA_W-1:0] : w_add < S_MIN ? S_MIN[DATA_W-1:0] : w_add[DATA_W-1:0];
   assign o_sum  = r_sum;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_prod <= '0;
         r_sum  <= '0;
      end else begin
         if (i_acc) r_prod <= (2*DATA_W)'(i_value) * (2*DATA_W)'(i_weight);
         if (i_load) r_sum <= i_bias;
         else if (i_add) r_sum <= w_sat;
      end
   end
endmodule

// File: rtl/neuron_layer_mac.sv
// neuron_layer_mac: NUM_NEURONS parallel saturating MAC lanes over a shared activation stream with a frame FSM.
// Defining NEURON_ARGMAX_EN adds out_class and a one-lane-per-cycle ARGMAX scan before DONE.
module neuron_layer_mac
   import neuron_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int FRAC_W      = 16,
   parameter int NUM_NEURONS = 10,
   parameter int NUM_INPUTS  = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [NUM_NEURONS*DATA_W-1:0] bias_flat,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [DATA_W-1:0]             in_value,
   input  logic [NUM_NEURONS*DATA_W-1:0] in_weights,
   output logic                          out_valid,
   output logic [NUM_NEURONS*DATA_W-1:0] out_sums,
`ifdef NEURON_ARGMAX_EN
   output logic [$clog2(NUM_NEURONS)-1:0] out_class,
`endif
   output logic                          busy
);
   localparam int CNT_W = $clog2(NUM_INPUTS + 1);
`ifdef NEURON_ARGMAX_EN
   localparam state_t S_AFTER = S_ARGMAX;
   localparam int     IW      = $clog2(NUM_NEURONS);
   logic [IW-1:0]            r_idx, r_class;
   logic signed [DATA_W-1:0] r_best, w_cur;
   logic                     w_scan_end;
`else
   localparam state_t S_AFTER = S_DONE;
`endif
   state_t           r_state, w_next;
   logic [CNT_W-1:0] r_cnt;
   logic             r_pv, r_ready, r_busy, r_valid, w_acc, w_last;
   // start owns the cycle: an input offered alongside it is not taken
   assign w_acc     = in_valid & r_ready & ~start;
   assign w_last    = r_cnt == CNT_W'(NUM_INPUTS - 1);
   assign in_ready  = r_ready;
   assign busy      = r_busy;
   assign out_valid = r_valid;
   always_comb begin
      w_next = r_state;
      if (start) w_next = S_ACCUM;
      else if (r_state == S_ACCUM && w_acc && w_last) w_next = S_DRAIN;
      else if (r_state == S_DRAIN && !r_pv) w_next = S_AFTER;
`ifdef NEURON_ARGMAX_EN
      else if (r_state == S_ARGMAX && w_scan_end) w_next = S_DONE;
`endif
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_pv    <= 1'b0;
         r_ready <= 1'b0;
         r_busy  <= 1'b0;
         r_valid <= 1'b0;
      end else begin
         r_state <= w_next;
         r_cnt   <= start ? '0 : w_acc ? r_cnt + 1'b1 : r_cnt;
         r_pv    <= w_acc;
         r_ready <= w_next == S_ACCUM;
         r_busy  <= w_next == S_ACCUM || w_next == S_DRAIN;
         r_valid <= w_next == S_DONE;
      end
   end
   for (genvar k = 0; k < NUM_NEURONS; k++) begin : g_lane
      neuron_mac_lane #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) u_lane (
         .clk      (clk),
         .rst      (rst),
         .i_load   (start),
         .i_acc    (w_acc),
         .i_add    (r_pv),
         .i_bias   (bias_flat[lane_lsb(k, DATA_W) +: DATA_W]),
         .i_value  (in_value),
         .i_weight (in_weights[lane_lsb(k, DATA_W) +: DATA_W]),
         .o_sum    (out_sums[lane_lsb(k, DATA_W) +: DATA_W])
      );
   end
`ifdef NEURON_ARGMAX_EN
   assign w_scan_end = r_idx == IW'(NUM_NEURONS - 1);
   assign w_cur      = out_sums[lane_lsb(int'(r_idx), DATA_W) +: DATA_W];
   assign out_class  = r_class;
   // strict greater-than keeps the lowest index on ties
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idx   <= '0;
         r_class <= '0;
         r_best  <= '0;
      end else if (r_state == S_ARGMAX) begin
         r_idx <= w_scan_end ? '0 : r_idx + 1'b1;
         if (r_idx == '0 || w_cur > r_best) begin
            r_best  <= w_cur;
            r_class <= r_idx;
         end
      end else begin
         r_idx <= '0;
      end
   end
`endif
endmodule

// File: tb/tb_neuron_layer_mac.sv
// tb_neuron_layer_mac: scoreboard bench for neuron_layer_mac; expected sums come from a longint fixed-point model.
module tb_neuron_layer_mac;
   localparam int DW = 32;
   localparam int NN = 10;
   localparam int NI = 32;
`ifdef NEURON_ARGMAX_EN
   localparam int LAT = 2 + NN;
`else
   localparam int LAT = 2;
`endif
   localparam longint MAXV = 2147483647;
   localparam longint MINV = -MAXV - 1;
   logic clk = 1'b0;
   logic rst, start, in_valid, in_ready, out_valid, busy;
   logic [NN*DW-1:0] bias_flat, in_weights, out_sums;
   logic [DW-1:0] in_value;
`ifdef NEURON_ARGMAX_EN
   logic [$clog2(NN)-1:0] out_class;
   int cq[$];
`endif
   int n_pass, n_tot;
   logic [DW-1:0] g_bias[NN];
   logic [DW-1:0] g_val[NI];
   logic [DW-1:0] g_wt[NI][NN];
   longint m_sum[NN];
   logic [DW-1:0] sq[$];

   always #5 clk = ~clk;

   neuron_layer_mac dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .bias_flat  (bias_flat),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_value   (in_value),
      .in_weights (in_weights),
      .out_valid  (out_valid),
      .out_sums   (out_sums),
`ifdef NEURON_ARGMAX_EN
      .out_class  (out_class),
`endif
      .busy       (busy)
   );

   function automatic longint clamp(input longint x);
      return x > MAXV ? MAXV : x < MINV ? MINV : x;
   endfunction

   // called at a negedge; start is seen by the next rising edge
   task automatic start_frame();
      for (int k = 0; k < NN; k++) begin
         bias_flat[k*DW +: DW] = g_bias[k];
         m_sum[k] = longint'($signed(g_bias[k]));
      end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic feed(input int n, input bit tog, input bit push);
      int i = 0;
      int cyc = 0;
      longint prod;
      while (i < n && cyc < 4 * n + 50) begin
         in_valid = tog ? ~cyc[0] : 1'b1;
         in_value = g_val[i];
         for (int k = 0; k < NN; k++) in_weights[k*DW +: DW] = g_wt[i][k];
         if (in_valid && in_ready) begin
            for (int k = 0; k < NN; k++) begin
               prod = longint'($signed(g_val[i])) * longint'($signed(g_wt[i][k]));
               m_sum[k] = clamp(m_sum[k] + clamp(prod >>> 16));
            end
            i++;
         end
         @(negedge clk);
         cyc++;
      end
      in_valid = 1'b0;
      n_tot++;
      if (i !== n) $display("FAIL feed accepts got %0d want %0d", i, n);
      else n_pass++;
      if (push) begin
         for (int k = 0; k < NN; k++) sq.push_back(m_sum[k][DW-1:0]);
`ifdef NEURON_ARGMAX_EN
         begin
            int best = 0;
            for (int k = 1; k < NN; k++) if (m_sum[k] > m_sum[best]) best = k;
            cq.push_back(best);
         end
`endif
      end
   endtask

   // entered at the negedge right after the edge that took the last input
   task automatic finish_frame(input string name);
      int c = 0;
      logic [DW-1:0] exp_sum;
      n_tot += 3;
      if (in_ready !== 1'b0) $display("FAIL %s drain_ready got %b want 0", name, in_ready); else n_pass++;
      if (busy !== 1'b1) $display("FAIL %s drain_busy got %b want 1", name, busy); else n_pass++;
      if (out_valid !== 1'b0) $display("FAIL %s early_valid got %b want 0", name, out_valid); else n_pass++;
      while (out_valid !== 1'b1 && c < LAT + 20) begin
         @(negedge clk);
         c++;
      end
      n_tot++;
      if (c !== LAT) $display("FAIL %s latency got %0d want %0d", name, c, LAT); else n_pass++;
      for (int k = 0; k < NN; k++) begin
         exp_sum = sq.pop_front();
         n_tot++;
         if (out_sums[k*DW +: DW] !== exp_sum)
            $display("FAIL %s sum lane%0d got %h want %h", name, k, out_sums[k*DW +: DW], exp_sum);
         else n_pass++;
      end
`ifdef NEURON_ARGMAX_EN
      begin
         int exp_cls = cq.pop_front();
         n_tot++;
         if (int'(out_class) !== exp_cls) $display("FAIL %s class got %0d want %0d", name, out_class, exp_cls);
         else n_pass++;
      end
`endif
      n_tot += 2;
      if (in_ready !== 1'b0) $display("FAIL %s done_ready got %b want 0", name, in_ready); else n_pass++;
      if (busy !== 1'b0) $display("FAIL %s done_busy got %b want 0", name, busy); else n_pass++;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_tot += 4;
      if (in_ready !== 1'b0) $display("FAIL reset in_ready got %b want 0", in_ready); else n_pass++;
      if (out_valid !== 1'b0) $display("FAIL reset out_valid got %b want 0", out_valid); else n_pass++;
      if (busy !== 1'b0) $display("FAIL reset busy got %b want 0", busy); else n_pass++;
      if (out_sums !== '0) $display("FAIL reset out_sums got %h want 0", out_sums); else n_pass++;
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic fill_basic();
      for (int k = 0; k < NN; k++) g_bias[k] = DW'(k * 32'h0001_0000);
      for (int i = 0; i < NI; i++) begin
         g_val[i] = 32'h0001_0000;
         for (int k = 0; k < NN; k++) g_wt[i][k] = 32'h0000_8000;
      end
   endtask

   task automatic test_basic();
      fill_basic();
      start_frame();
      feed(NI, 1'b0, 1'b1);
      finish_frame("basic");
      n_tot++;
      if (out_sums[9*DW +: DW] !== 32'h0019_0000) $display("FAIL basic lane9 got %h want 00190000", out_sums[9*DW +: DW]);
      else n_pass++;
   endtask

   task automatic test_toggle();
      fill_basic();
      start_frame();
      feed(NI, 1'b1, 1'b1);
      finish_frame("toggle");
   endtask

   task automatic test_random();
      for (int k = 0; k < NN; k++) g_bias[k] = $urandom_range(0, 32'h0080_0000) - 32'h0040_0000;
      for (int i = 0; i < NI; i++) begin
         g_val[i] = $urandom_range(0, 32'h0008_0000) - 32'h0004_0000;
         for (int k = 0; k < NN; k++) g_wt[i][k] = $urandom_range(0, 32'h0008_0000) - 32'h0004_0000;
      end
      start_frame();
      feed(NI, 1'b0, 1'b1);
      finish_frame("rand_small");
      for (int k = 0; k < NN; k++) g_bias[k] = $urandom;
      for (int i = 0; i < NI; i++) begin
         g_val[i] = $urandom;
         for (int k = 0; k < NN; k++) g_wt[i][k] = $urandom;
      end
      start_frame();
      feed(NI, 1'b1, 1'b1);
      finish_frame("rand_full");
   endtask

   task automatic test_saturation();
      for (int k = 0; k < NN; k++) g_bias[k] = 32'h7FFF_0000;
      for (int i = 0; i < NI; i++) begin
         g_val[i] = 32'h7FFF_FFFF;
         for (int k = 0; k < NN; k++) g_wt[i][k] = 32'h7FFF_FFFF;
      end
      start_frame();
      feed(NI, 1'b0, 1'b1);
      finish_frame("sat_pos");
      n_tot++;
      if (out_sums[0 +: DW] !== 32'h7FFF_FFFF) $display("FAIL sat_pos lane0 got %h want 7fffffff", out_sums[0 +: DW]);
      else n_pass++;
      for (int i = 0; i < NI; i++) for (int k = 0; k < NN; k++) g_wt[i][k] = 32'h8000_0001;
      start_frame();
      feed(NI, 1'b0, 1'b1);
      finish_frame("sat_neg");
      n_tot++;
      if (out_sums[0 +: DW] !== 32'h8000_0000) $display("FAIL sat_neg lane0 got %h want 80000000", out_sums[0 +: DW]);
      else n_pass++;
   endtask

   task automatic test_restart();
      for (int k = 0; k < NN; k++) g_bias[k] = DW'(k * 32'h0000_1000);
      for (int i = 0; i < NI; i++) begin
         g_val[i] = $urandom_range(0, 32'h0004_0000) - 32'h0002_0000;
         for (int k = 0; k < NN; k++) g_wt[i][k] = $urandom_range(0, 32'h0004_0000) - 32'h0002_0000 + 32'h0001_0000;
      end
      start_frame();
      n_tot += 2;
      if (out_valid !== 1'b0) $display("FAIL restart valid_drop got %b want 0", out_valid); else n_pass++;
      if (busy !== 1'b1) $display("FAIL restart busy got %b want 1", busy); else n_pass++;
      feed(10, 1'b0, 1'b0);
      for (int k = 0; k < NN; k++) g_bias[k] = DW'(32'h0030_0000 - k * 32'h0002_0000);
      start_frame();
      for (int k = 0; k < NN; k++) begin
         n_tot++;
         if (out_sums[k*DW +: DW] !== g_bias[k])
            $display("FAIL restart reload lane%0d got %h want %h", k, out_sums[k*DW +: DW], g_bias[k]);
         else n_pass++;
      end
      feed(NI, 1'b0, 1'b1);
      finish_frame("restart");
   endtask

   task automatic test_rst_mid();
      fill_basic();
      start_frame();
      feed(5, 1'b0, 1'b0);
      rst = 1'b1;
      #1;
      n_tot += 4;
      if (in_ready !== 1'b0) $display("FAIL rst_mid in_ready got %b want 0", in_ready); else n_pass++;
      if (busy !== 1'b0) $display("FAIL rst_mid busy got %b want 0", busy); else n_pass++;
      if (out_valid !== 1'b0) $display("FAIL rst_mid out_valid got %b want 0", out_valid); else n_pass++;
      if (out_sums !== '0) $display("FAIL rst_mid out_sums got %h want 0", out_sums); else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      in_valid = 1'b1;
      repeat (3) @(negedge clk);
      n_tot += 3;
      if (in_ready !== 1'b0) $display("FAIL rst_idle in_ready got %b want 0", in_ready); else n_pass++;
      if (busy !== 1'b0) $display("FAIL rst_idle busy got %b want 0", busy); else n_pass++;
      if (out_sums !== '0) $display("FAIL rst_idle out_sums got %h want 0", out_sums); else n_pass++;
      in_valid = 1'b0;
   endtask

`ifdef NEURON_ARGMAX_EN
   task automatic test_argmax();
      for (int i = 0; i < NI; i++) begin
         g_val[i] = 32'h0001_0000;
         for (int k = 0; k < NN; k++) g_wt[i][k] = '0;
      end
      for (int k = 0; k < NN; k++) g_bias[k] = DW'(k * 32'h0001_0000);
      g_bias[0] = 32'hFFF0_0000;
      g_bias[7] = 32'h0050_0000;
      start_frame();
      feed(NI, 1'b0, 1'b1);
      finish_frame("argmax_max7");
      g_bias[3] = 32'h0050_0000;
      start_frame();
      feed(NI, 1'b0, 1'b1);
      finish_frame("argmax_tie");
   endtask
`endif

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      n_pass = 0;
      n_tot = 0;
      rst = 1'b1;
      start = 1'b0;
      in_valid = 1'b0;
      in_value = '0;
      bias_flat = '0;
      in_weights = '0;
      test_reset();
      test_basic();
      test_toggle();
      test_random();
      test_saturation();
      test_restart();
      test_rst_mid();
`ifdef NEURON_ARGMAX_EN
      test_argmax();
`endif
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
